// File: rtl/capture_pkg.sv
// Shared types and default sizing for the vector capture block.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2,
    DUMP    = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/capture_mem.sv
// Capture storage: DEPTH x DATA_W registers, synchronous write, combinational read.
module capture_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/vector_capture.sv
// Captures up to DEPTH sample vectors, then streams them out in capture order
// with a valid/ready handshake; contents survive a dump so it can be replayed.
module vector_capture
  import capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_arm,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_dump,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic                     o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t            state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [AW-1:0]     rd_ptr, rd_addr;
  logic [DATA_W-1:0] rd_data, first_data;
  logic              wr_en, restart, start_dump, advance, finish, set_ovf;

  capture_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (count[AW-1:0]),
    .i_wdata (i_data),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    restart    = 1'b0;
    start_dump = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      IDLE: begin
        if (i_arm) begin
          restart   = 1'b1;
          state_nxt = CAPTURE;
        end else if (i_dump) begin
          start_dump = 1'b1;
          state_nxt  = DUMP;
        end
      end
      CAPTURE: begin
        if (i_arm) begin
          restart   = 1'b1;
          state_nxt = CAPTURE;
        end else begin
          wr_en = i_valid;
          if (i_dump) begin
            start_dump = 1'b1;
            state_nxt  = DUMP;
          end else if (i_valid && count == DEPTH_C - CW'(1)) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_arm) begin
          restart   = 1'b1;
          state_nxt = CAPTURE;
        end else begin
          set_ovf = i_valid;
          if (i_dump) begin
            start_dump = 1'b1;
            state_nxt  = DUMP;
          end
        end
      end
      DUMP: begin
        // o_valid low here means an empty dump: its done pulse already fired
        if (!o_valid) begin
          state_nxt = IDLE;
        end else if (i_ready) begin
          if (CW'(rd_ptr) + CW'(1) == count) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign count_nxt = count + CW'(wr_en);
  assign rd_addr   = start_dump ? '0 : rd_ptr + AW'(1);
  // A sample written on the dump entry edge into an empty store is entry 0 itself
  assign first_data = (wr_en && count == '0) ? i_data : rd_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      count      <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
      o_done     <= 1'b0;
      o_data     <= '0;
    end else begin
      o_done <= 1'b0;
      if (restart)    count <= '0;
      else if (wr_en) count <= count_nxt;
      if (restart)      o_overflow <= 1'b0;
      else if (set_ovf) o_overflow <= 1'b1;
      if (start_dump) begin
        rd_ptr <= '0;
        if (count_nxt == '0) begin
          o_done <= 1'b1;
        end else begin
          o_valid <= 1'b1;
          o_data  <= first_data;
        end
      end
      if (advance) begin
        rd_ptr <= rd_ptr + AW'(1);
        o_data <= rd_data;
      end
      if (finish) begin
        o_valid <= 1'b0;
        o_done  <= 1'b1;
      end
    end
  end

  assign o_count = count;
  assign o_full  = (count == DEPTH_C);

endmodule

// File: tb/tb_vector_capture.sv
// Bench for vector_capture: scoreboarded dumps, a vector table for arm/capture
// sequencing, and hand-written reset, overflow and backpressure sequences.
module tb_vector_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              i_reset, i_arm, i_valid, i_dump, i_ready;
  logic [DATA_W-1:0] i_data;
  logic [DATA_W-1:0] o_data;
  logic              o_valid, o_full, o_overflow, o_done;
  logic [4:0]        o_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap[$];

  typedef struct {
    logic       arm;
    logic       valid;
    logic       dump;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_valid;
    logic       exp_done;
  } vec_t;

  vec_t tbl[9];

  vector_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_arm      (i_arm),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_dump     (i_dump),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard the transfer about to happen, then verify hold-stability.
  task automatic cyc();
    logic       hold;
    logic [7:0] held;
    hold = (i_reset === 1'b1) && (o_valid === 1'b1) && (i_ready === 1'b0);
    held = o_data;
    if ((i_reset === 1'b1) && (o_valid === 1'b1) && (i_ready === 1'b1)) begin
      if (exp_q.size() == 0) chk("unexpected_output", o_valid, 0);
      else                   chk("dump_data", o_data, exp_q.pop_front());
    end
    @(posedge clk); #1;
    if (hold) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, held);
    end
  endtask

  task automatic arm();
    i_arm = 1'b1;
    cyc();
    i_arm = 1'b0;
    cap.delete();
    chk("arm_count", o_count, 0);
    chk("arm_ovf", o_overflow, 0);
  endtask

  task automatic sample(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    if (cap.size() < DEPTH) cap.push_back(d);
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic do_dump(input logic [7:0] pat, input int plen, output int cycles);
    int n, k, done_cnt;
    n = cap.size();
    foreach (cap[i]) exp_q.push_back(cap[i]);
    i_dump  = 1'b1;
    i_ready = (n == 0);
    cyc();
    i_dump = 1'b0;
    chk("dump_entry_valid", o_valid, n > 0);
    chk("dump_entry_done", o_done, n == 0);
    done_cnt = o_done;
    k = 0;
    cycles = 0;
    while (o_valid === 1'b1 && cycles < 64) begin
      i_ready = pat[k % plen];
      k++;
      cyc();
      done_cnt += o_done;
      cycles++;
    end
    if (cycles >= 64) chk("dump_timeout", cycles, 0);
    i_ready = 1'b0;
    cyc();
    done_cnt += o_done;
    chk("dump_valid_after", o_valid, 0);
    chk("dump_done_pulses", done_cnt, 1);
    chk("dump_drained", exp_q.size(), 0);
    chk("dump_count_kept", o_count, n);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc_n;
    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 8'hA1, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 8'hA2, 2, 0, 0};
    tbl[3] = '{0, 0, 0, 8'h00, 2, 0, 0};
    tbl[4] = '{0, 1, 0, 8'hA3, 3, 0, 0};
    tbl[5] = '{0, 1, 0, 8'hA4, 4, 0, 0};
    tbl[6] = '{1, 1, 1, 8'hEE, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 8'h00, 0, 0, 0};
    tbl[8] = '{0, 1, 0, 8'hB0, 1, 0, 0};

    i_reset = 1'b0; i_arm = 1'b0; i_valid = 1'b0; i_dump = 1'b0;
    i_ready = 1'b0; i_data = '0;
    repeat (3) cyc();
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_full", o_full, 0);
    chk("rst_data", o_data, 0);
    i_reset = 1'b1;
    cyc();

    // Five samples with gaps, full-rate dump, then replay
    arm();
    sample(8'h11); sample(8'h12); cyc(); sample(8'h13); cyc(); cyc();
    sample(8'h14); sample(8'h15);
    chk("five_count", o_count, 5);
    do_dump(8'hFF, 1, cyc_n);
    chk("five_consecutive", cyc_n, 5);
    do_dump(8'hFF, 1, cyc_n);
    chk("replay_consecutive", cyc_n, 5);

    // Backpressure pattern 1,0,0,1,0,1
    arm();
    sample(8'hC0); sample(8'hC1); sample(8'hC2);
    do_dump(8'h29, 6, cyc_n);
    chk("bp_cycles", cyc_n, 6);

    // Fill past DEPTH
    arm();
    for (int i = 0; i < 18; i++) begin
      sample(8'(i));
      chk("fill_count", o_count, (i < DEPTH) ? i + 1 : DEPTH);
      chk("fill_full", o_full, i >= DEPTH - 1);
      chk("fill_ovf", o_overflow, i >= DEPTH);
    end
    do_dump(8'hFF, 1, cyc_n);
    chk("fill_dump_len", cyc_n, DEPTH);
    chk("fill_full_kept", o_full, 1);

    // Empty dump
    arm();
    do_dump(8'hFF, 1, cyc_n);
    chk("empty_cycles", cyc_n, 0);

    // arm/capture table, ending with arm+dump priority and resumed capture
    foreach (tbl[i]) begin
      i_arm = tbl[i].arm; i_valid = tbl[i].valid; i_dump = tbl[i].dump;
      i_data = tbl[i].data; i_ready = 1'b0;
      cyc();
      chk($sformatf("tbl%0d_count", i), o_count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_done", i), o_done, tbl[i].exp_done);
    end
    i_arm = 1'b0; i_valid = 1'b0; i_dump = 1'b0;

    // Reset in the middle of a dump
    arm();
    sample(8'hD0); sample(8'hD1); sample(8'hD2); sample(8'hD3);
    foreach (cap[i]) exp_q.push_back(cap[i]);
    i_dump = 1'b1;
    cyc();
    i_dump = 1'b0;
    chk("mid_entry_valid", o_valid, 1);
    i_ready = 1'b1;
    cyc(); cyc();
    chk("mid_two_left", exp_q.size(), 2);
    i_ready = 1'b0;
    i_reset = 1'b0;
    cyc();
    i_reset = 1'b1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_data", o_data, 0);
    exp_q.delete();
    cap.delete();
    do_dump(8'hFF, 1, cyc_n);
    chk("mid_after_cycles", cyc_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
